// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, registered carry.
// Start/busy/done handshake; result and flags hold until the next accepted start.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_c_msb;
    logic             r_cout;
    logic             r_ovf;

    logic w_sum;
    logic w_co;
    logic w_accept;

    assign w_sum = r_opa[0] ^ r_opb[0] ^ r_carry;
    assign w_co  = (r_opa[0] & r_opb[0]) | (r_carry & (r_opa[0] ^ r_opb[0]));
    assign w_accept = (r_state == S_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_c_msb  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            r_opa    <= r_opa >> 1;
            r_opb    <= r_opb >> 1;
            r_carry  <= w_co;
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == PRE) begin
                r_c_msb <= w_co;
            end
            if (r_cnt == LAST) begin
                r_cout <= w_co;
                r_ovf  <= r_c_msb ^ w_co;
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign c_out    = r_cout;
    assign overflow = r_ovf;

endmodule
